// File: rtl/float_to_fixed.sv
// float_to_fixed: streaming IEEE-style float -> signed fixed-point converter.
// 3-stage pipeline (decode, align, round/saturate) with valid/ready on both sides.
// Ports: aclk/aresetn (sync, active-high), s_axis_a_* float in,
//        m_axis_result_* fixed out, flag = {nan, overflow, inexact}.
module float_to_fixed #(
   parameter int EXP = 5,
   parameter int FRA = 10,
   parameter int IW  = 8,
   parameter int FW  = 8
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [EXP+FRA:0]     s_axis_a_tdata,
   input  logic                 s_axis_a_tvalid,
   output logic                 s_axis_a_tready,
   output logic [IW+FW-1:0]     m_axis_result_tdata,
   output logic                 m_axis_result_tvalid,
   input  logic                 m_axis_result_tready,
   output logic [2:0]           flag
);
   localparam int WID  = IW + FW;
   localparam int DW   = EXP + FRA + 1;
   localparam int MW   = FRA + 1;
   localparam int AW   = MW + WID + 1;
   localparam int BIAS = 2**(EXP-1) - 1;
   localparam int SW   = EXP + $clog2(AW + FRA + FW + 4) + 2;

   localparam logic signed [SW-1:0] OFFS = SW'(BIAS + FRA - FW);
   localparam logic signed [SW-1:0] LMAX = SW'(WID + 1);
   localparam logic signed [SW-1:0] RMAX = SW'(FRA + 2);
   localparam logic [WID+1:0] NEGLIM = {2'b00, 1'b1, {(WID-1){1'b0}}};
   localparam logic [WID+1:0] POSLIM = NEGLIM - 1'b1;

   logic w_en;
   assign w_en            = !m_axis_result_tvalid || m_axis_result_tready;
   assign s_axis_a_tready = w_en && !aresetn;

   // stage 1: decode
   logic                 w_s;
   logic [EXP-1:0]       w_e;
   logic [FRA-1:0]       w_f;
   logic                 w_ezero;
   logic                 w_eones;
   logic [EXP-1:0]       w_emax;
   logic signed [SW-1:0] w_sh;

   assign w_s     = s_axis_a_tdata[DW-1];
   assign w_e     = s_axis_a_tdata[DW-2:FRA];
   assign w_f     = s_axis_a_tdata[FRA-1:0];
   assign w_ezero = (w_e == '0);
   assign w_eones = &w_e;
   assign w_emax  = w_ezero ? {{(EXP-1){1'b0}}, 1'b1} : w_e;
   // shift that places the significand in units of 2^-FW
   assign w_sh    = $signed({{(SW-EXP){1'b0}}, w_emax}) - OFFS;

   logic                 r1_v, r1_s, r1_nan, r1_inf;
   logic [MW-1:0]        r1_m;
   logic signed [SW-1:0] r1_sh;

   // stage 2: align
   logic                 w_left;
   logic signed [SW-1:0] w_lc, w_rn, w_rc;
   logic [AW-1:0]        w_lwide;
   logic [2*MW:0]        w_rwide;
   logic [AW-1:0]        w_aw;

   assign w_left  = !r1_sh[SW-1];
   assign w_lc    = (r1_sh > LMAX) ? LMAX : r1_sh;
   assign w_rn    = -r1_sh;
   assign w_rc    = (w_rn > RMAX) ? RMAX : w_rn;
   // left shift clamped: anything pushed past WID lands in the overflow bits
   assign w_lwide = {{(WID+1){1'b0}}, r1_m} << w_lc;
   // right shift into a zero tail: [MW] is guard, below it sticky
   assign w_rwide = {r1_m, {(MW+1){1'b0}}} >> w_rc;
   assign w_aw    = w_left ? w_lwide
                           : {{(AW-MW){1'b0}}, w_rwide[2*MW:MW+1]};

   logic           r2_v, r2_s, r2_nan, r2_inf;
   logic           r2_big, r2_g, r2_st;
   logic [WID:0]   r2_mag;

   // stage 3: round, sign, saturate
   logic           w_inc;
   logic [WID+1:0] w_sum;
   logic           w_ovf;
   logic [WID-1:0] w_d;
   logic [2:0]     w_fl;

   assign w_inc = r2_g && (r2_st || r2_mag[0]);
   assign w_sum = {1'b0, r2_mag} + {{(WID+1){1'b0}}, w_inc};
   // -2^(WID-1) is representable, +2^(WID-1) is not
   assign w_ovf = r2_inf || r2_big ||
                  (r2_s ? (w_sum > NEGLIM) : (w_sum > POSLIM));

   always_comb begin
      w_d  = '0;
      w_fl = 3'b000;
      unique case (1'b1)
         r2_nan: begin
            w_d  = '0;
            w_fl = 3'b100;
         end
         (!r2_nan && w_ovf): begin
            w_d  = r2_s ? {1'b1, {(WID-1){1'b0}}}
                        : {1'b0, {(WID-1){1'b1}}};
            w_fl = 3'b010;
         end
         default: begin
            w_d  = r2_s ? ({WID{1'b0}} - w_sum[WID-1:0])
                        : w_sum[WID-1:0];
            w_fl = {2'b00, r2_g || r2_st};
         end
      endcase
   end

   logic           r_ov;
   logic [WID-1:0] r_od;
   logic [2:0]     r_of;

   always_ff @(posedge aclk) begin
      if (aresetn) begin
         r1_v   <= 1'b0;
         r1_s   <= 1'b0;
         r1_nan <= 1'b0;
         r1_inf <= 1'b0;
         r1_m   <= '0;
         r1_sh  <= '0;
         r2_v   <= 1'b0;
         r2_s   <= 1'b0;
         r2_nan <= 1'b0;
         r2_inf <= 1'b0;
         r2_big <= 1'b0;
         r2_g   <= 1'b0;
         r2_st  <= 1'b0;
         r2_mag <= '0;
         r_ov   <= 1'b0;
         r_od   <= '0;
         r_of   <= '0;
      end else if (w_en) begin
         r1_v   <= s_axis_a_tvalid;
         r1_s   <= w_s;
         r1_nan <= w_eones && (w_f != '0);
         r1_inf <= w_eones && (w_f == '0);
         r1_m   <= {!w_ezero, w_f};
         r1_sh  <= w_sh;
         r2_v   <= r1_v;
         r2_s   <= r1_s;
         r2_nan <= r1_nan;
         r2_inf <= r1_inf;
         r2_mag <= w_aw[WID:0];
         r2_big <= |w_aw[AW-1:WID+1];
         r2_g   <= !w_left && w_rwide[MW];
         r2_st  <= !w_left && (|w_rwide[MW-1:0]);
         r_ov   <= r2_v;
         r_od   <= w_d;
         r_of   <= w_fl;
      end
   end

   assign m_axis_result_tvalid = r_ov;
   assign m_axis_result_tdata  = r_od;
   assign flag                 = r_of;
endmodule

// File: tb/tb_float_to_fixed.sv
// tb_float_to_fixed: directed and randomised checks of float_to_fixed
// (half precision in, Q8.8 out) against hand values and a ratio model.
module tb_float_to_fixed;
   logic        aclk;
   logic        aresetn;
   logic [15:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic [15:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic [2:0]  flag;

   int errs;
   int checks;

   logic [15:0] v_in [16];
   logic [15:0] r_d  [16];
   logic [2:0]  r_f  [16];
   int          n_in;
   int          n_got;

   float_to_fixed dut (
      .aclk                 (aclk),
      .aresetn              (aresetn),
      .s_axis_a_tdata       (s_tdata),
      .s_axis_a_tvalid      (s_tvalid),
      .s_axis_a_tready      (s_tready),
      .m_axis_result_tdata  (m_tdata),
      .m_axis_result_tvalid (m_tvalid),
      .m_axis_result_tready (m_tready),
      .flag                 (flag)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // value scaled by 2^40 so every half-precision input is an exact integer
   function automatic void model(input logic [15:0] x,
                                 output logic [15:0] d,
                                 output logic [2:0] f);
      logic            s;
      logic [4:0]      e;
      logic [9:0]      fr;
      longint unsigned m, n, q, rem, half;
      int              sh;
      s  = x[15];
      e  = x[14:10];
      fr = x[9:0];
      d  = 16'h0000;
      f  = 3'b000;
      if (e == 5'd31) begin
         if (fr != 10'd0) begin
            d = 16'h0000;
            f = 3'b100;
         end else begin
            d = s ? 16'h8000 : 16'h7FFF;
            f = 3'b010;
         end
         return;
      end
      m    = longint'({e != 5'd0, fr});
      sh   = ((e == 5'd0) ? 1 : int'(e)) - 15 - 10 + 8 + 40;
      n    = m << sh;
      q    = n >> 40;
      half = 64'd1 << 39;
      rem  = n & ((64'd1 << 40) - 64'd1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if ((!s && q > 64'd32767) || (s && q > 64'd32768)) begin
         d = s ? 16'h8000 : 16'h7FFF;
         f = 3'b010;
      end else begin
         d = s ? (16'h0000 - q[15:0]) : q[15:0];
         f = {2'b00, rem != 64'd0};
      end
   endfunction

   task automatic stream();
      int idx;
      idx   = 0;
      n_got = 0;
      for (int c = 0; c < n_in + 20 && n_got < n_in; c++) begin
         @(negedge aclk);
         m_tready = 1'b1;
         s_tvalid = (idx < n_in);
         s_tdata  = v_in[(idx < n_in) ? idx : 0];
         #1;
         if (m_tvalid && m_tready) begin
            r_d[n_got] = m_tdata;
            r_f[n_got] = flag;
            n_got++;
         end
         if (s_tvalid && s_tready) idx++;
      end
      @(negedge aclk);
      s_tvalid = 1'b0;
   endtask

   task automatic test_reset();
      aresetn  = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = 16'h3C00;
      m_tready = 1'b1;
      repeat (3) @(negedge aclk);
      #1;
      checks++;
      if (m_tvalid !== 1'b0) begin
         errs++;
         $display("FAIL reset_tvalid: got %b want 0", m_tvalid);
      end
      checks++;
      if (m_tdata !== 16'h0000) begin
         errs++;
         $display("FAIL reset_tdata: got %h want 0000", m_tdata);
      end
      checks++;
      if (flag !== 3'b000) begin
         errs++;
         $display("FAIL reset_flag: got %b want 000", flag);
      end
      checks++;
      if (s_tready !== 1'b0) begin
         errs++;
         $display("FAIL reset_tready: got %b want 0", s_tready);
      end
      @(negedge aclk);
      aresetn  = 1'b0;
      s_tvalid = 1'b0;
      #1;
      checks++;
      if (s_tready !== 1'b1) begin
         errs++;
         $display("FAIL post_reset_tready: got %b want 1", s_tready);
      end
   endtask

   task automatic test_single(input logic [15:0] x,
                              input logic [15:0] ed,
                              input logic [2:0] ef);
      int          lat;
      logic [15:0] gd;
      logic [2:0]  gf;
      logic        acc;
      lat = 0;
      gd  = 16'hxxxx;
      gf  = 3'bxxx;
      @(negedge aclk);
      s_tvalid = 1'b1;
      s_tdata  = x;
      m_tready = 1'b1;
      #1;
      acc = s_tvalid && s_tready;
      checks++;
      if (acc !== 1'b1) begin
         errs++;
         $display("FAIL single_accept %h: got %b want 1", x, acc);
      end
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         @(negedge aclk);
         s_tvalid = 1'b0;
         #1;
         if (m_tvalid) begin
            lat = c;
            gd  = m_tdata;
            gf  = flag;
         end
      end
      checks++;
      if (lat != 3) begin
         errs++;
         $display("FAIL single_latency %h: got %0d want 3", x, lat);
      end
      checks++;
      if (gd !== ed || gf !== ef) begin
         errs++;
         $display("FAIL single_value %h: got %h/%b want %h/%b",
                  x, gd, gf, ed, ef);
      end
      @(negedge aclk);
      #1;
      checks++;
      if (m_tvalid !== 1'b0) begin
         errs++;
         $display("FAIL single_dup %h: got tvalid %b want 0", x, m_tvalid);
      end
   endtask

   task automatic test_rounding();
      logic [15:0] ed [8];
      logic [2:0]  ef [8];
      v_in[0] = 16'h2E66; ed[0] = 16'h001A; ef[0] = 3'b001;
      v_in[1] = 16'h3266; ed[1] = 16'h0033; ef[1] = 3'b001;
      v_in[2] = 16'h1800; ed[2] = 16'h0000; ef[2] = 3'b001;
      v_in[3] = 16'h1E00; ed[3] = 16'h0002; ef[3] = 3'b001;
      v_in[4] = 16'h0001; ed[4] = 16'h0000; ef[4] = 3'b001;
      v_in[5] = 16'hAE66; ed[5] = 16'hFFE6; ef[5] = 3'b001;
      v_in[6] = 16'h57FF; ed[6] = 16'h7FF0; ef[6] = 3'b000;
      v_in[7] = 16'h3E00; ed[7] = 16'h0180; ef[7] = 3'b000;
      n_in = 8;
      stream();
      checks++;
      if (n_got != n_in) begin
         errs++;
         $display("FAIL round_count: got %0d want %0d", n_got, n_in);
      end
      for (int i = 0; i < n_got && i < n_in; i++) begin
         checks++;
         if (r_d[i] !== ed[i] || r_f[i] !== ef[i]) begin
            errs++;
            $display("FAIL round %h: got %h/%b want %h/%b",
                     v_in[i], r_d[i], r_f[i], ed[i], ef[i]);
         end
      end
   endtask

   task automatic test_specials();
      logic [15:0] ed [10];
      logic [2:0]  ef [10];
      v_in[0] = 16'h5800; ed[0] = 16'h7FFF; ef[0] = 3'b010;
      v_in[1] = 16'hD800; ed[1] = 16'h8000; ef[1] = 3'b000;
      v_in[2] = 16'h7C00; ed[2] = 16'h7FFF; ef[2] = 3'b010;
      v_in[3] = 16'hFC00; ed[3] = 16'h8000; ef[3] = 3'b010;
      v_in[4] = 16'h7E00; ed[4] = 16'h0000; ef[4] = 3'b100;
      v_in[5] = 16'h8000; ed[5] = 16'h0000; ef[5] = 3'b000;
      v_in[6] = 16'h0000; ed[6] = 16'h0000; ef[6] = 3'b000;
      v_in[7] = 16'h7BFF; ed[7] = 16'h7FFF; ef[7] = 3'b010;
      v_in[8] = 16'hD801; ed[8] = 16'h8000; ef[8] = 3'b010;
      v_in[9] = 16'hFE00; ed[9] = 16'h0000; ef[9] = 3'b100;
      n_in = 10;
      stream();
      checks++;
      if (n_got != n_in) begin
         errs++;
         $display("FAIL special_count: got %0d want %0d", n_got, n_in);
      end
      for (int i = 0; i < n_got && i < n_in; i++) begin
         checks++;
         if (r_d[i] !== ed[i] || r_f[i] !== ef[i]) begin
            errs++;
            $display("FAIL special %h: got %h/%b want %h/%b",
                     v_in[i], r_d[i], r_f[i], ed[i], ef[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] bi [5];
      logic [15:0] be [5];
      logic [15:0] hd;
      logic [2:0]  hf;
      logic        held;
      logic        rdy;
      int          idx, bad, extra;
      bi[0] = 16'h3C00; be[0] = 16'h0100;
      bi[1] = 16'h4000; be[1] = 16'h0200;
      bi[2] = 16'h4200; be[2] = 16'h0300;
      bi[3] = 16'h4400; be[3] = 16'h0400;
      bi[4] = 16'h4500; be[4] = 16'h0500;
      idx   = 0;
      bad   = 0;
      extra = 0;
      held  = 1'b0;
      hd    = 16'h0000;
      hf    = 3'b000;
      rdy   = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge aclk);
         m_tready = 1'b0;
         s_tvalid = (idx < 5);
         s_tdata  = bi[(idx < 5) ? idx : 0];
         #1;
         if (m_tvalid) begin
            if (!held) begin
               hd   = m_tdata;
               hf   = flag;
               held = 1'b1;
            end else if (m_tdata !== hd || flag !== hf) begin
               bad++;
            end
         end
         rdy = s_tready;
         if (s_tvalid && s_tready) idx++;
      end
      checks++;
      if (idx != 3) begin
         errs++;
         $display("FAIL bp_accepted: got %0d want 3", idx);
      end
      checks++;
      if (rdy !== 1'b0) begin
         errs++;
         $display("FAIL bp_tready: got %b want 0", rdy);
      end
      checks++;
      if (bad != 0 || hd !== 16'h0100) begin
         errs++;
         $display("FAIL bp_stable: changes %0d head %h want 0 0100", bad, hd);
      end
      n_got = 0;
      for (int c = 0; c < 30 && n_got < 5; c++) begin
         @(negedge aclk);
         m_tready = 1'b1;
         s_tvalid = (idx < 5);
         s_tdata  = bi[(idx < 5) ? idx : 0];
         #1;
         if (m_tvalid) begin
            r_d[n_got] = m_tdata;
            n_got++;
         end
         if (s_tvalid && s_tready) idx++;
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge aclk);
         s_tvalid = 1'b0;
         #1;
         if (m_tvalid) extra++;
      end
      checks++;
      if (n_got != 5 || extra != 0) begin
         errs++;
         $display("FAIL bp_count: got %0d+%0d want 5+0", n_got, extra);
      end
      for (int i = 0; i < n_got && i < 5; i++) begin
         checks++;
         if (r_d[i] !== be[i]) begin
            errs++;
            $display("FAIL bp_order %0d: got %h want %h", i, r_d[i], be[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] qd [$];
      logic [2:0]  qf [$];
      logic [15:0] ed, pd;
      logic [2:0]  ef, pf;
      logic        acc, pstall;
      int          sent, rcvd;
      sent   = 0;
      rcvd   = 0;
      acc    = 1'b0;
      pstall = 1'b0;
      pd     = 16'h0000;
      pf     = 3'b000;
      for (int c = 0; c < 20000 && rcvd < 1000; c++) begin
         @(negedge aclk);
         if (acc) s_tvalid = 1'b0;
         if (!s_tvalid && sent < 1000 && $urandom_range(0, 3) != 0) begin
            s_tvalid = 1'b1;
            s_tdata  = 16'($urandom);
         end
         m_tready = 1'($urandom_range(0, 1));
         #1;
         if (pstall) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== pd || flag !== pf) begin
               errs++;
               $display("FAIL rand_hold: got %b %h/%b want 1 %h/%b",
                        m_tvalid, m_tdata, flag, pd, pf);
            end
         end
         if (m_tvalid && m_tready) begin
            checks++;
            if (qd.size() == 0) begin
               errs++;
               $display("FAIL rand_extra: got %h want none", m_tdata);
            end else begin
               ed = qd.pop_front();
               ef = qf.pop_front();
               if (m_tdata !== ed || flag !== ef) begin
                  errs++;
                  $display("FAIL rand_value %0d: got %h/%b want %h/%b",
                           rcvd, m_tdata, flag, ed, ef);
               end
            end
            rcvd++;
         end
         pstall = m_tvalid && !m_tready;
         pd     = m_tdata;
         pf     = flag;
         acc    = s_tvalid && s_tready;
         if (acc) begin
            model(s_tdata, ed, ef);
            qd.push_back(ed);
            qf.push_back(ef);
            sent++;
         end
      end
      @(negedge aclk);
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      checks++;
      if (rcvd != 1000 || qd.size() != 0) begin
         errs++;
         $display("FAIL rand_count: got %0d left %0d want 1000 0",
                  rcvd, qd.size());
      end
   endtask

   task automatic test_reset_mid();
      int stale;
      stale = 0;
      @(negedge aclk);
      m_tready = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = 16'h4000;
      @(negedge aclk);
      s_tdata  = 16'h4200;
      @(negedge aclk);
      s_tvalid = 1'b0;
      aresetn  = 1'b1;
      @(negedge aclk);
      aresetn  = 1'b0;
      #1;
      checks++;
      if (m_tvalid !== 1'b0 || flag !== 3'b000) begin
         errs++;
         $display("FAIL mid_reset: got %b/%b want 0/000", m_tvalid, flag);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge aclk);
         #1;
         if (m_tvalid) stale++;
      end
      checks++;
      if (stale != 0) begin
         errs++;
         $display("FAIL mid_stale: got %0d want 0", stale);
      end
      test_single(16'h3C00, 16'h0100, 3'b000);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      errs     = 0;
      checks   = 0;
      aresetn  = 1'b1;
      s_tvalid = 1'b0;
      s_tdata  = 16'h0000;
      m_tready = 1'b0;
      n_in     = 0;
      n_got    = 0;
      test_reset();
      test_single(16'h3C00, 16'h0100, 3'b000);
      test_single(16'hC000, 16'hFE00, 3'b000);
      test_rounding();
      test_specials();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
